// File: rtl/min_arbiter.sv
// Four-way arbiter granting the requester with the smallest key; ties go round-robin.
// Define MIN_ARB_AGING_EN to compile in per-lane age counters that lower effective keys.
module min_arbiter #(
  parameter int KEY_W    = 8,
  parameter int HOLD_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [KEY_W-1:0] key0,
  input  logic [KEY_W-1:0] key1,
  input  logic [KEY_W-1:0] key2,
  input  logic [KEY_W-1:0] key3,
  input  logic             done,
  output logic [3:0]       gnt,
  output logic [1:0]       gnt_id,
  output logic [KEY_W-1:0] gnt_key,
  output logic             busy,
  output logic             timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_GRANT} state_e;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_e           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       gnt_id_q, gnt_id_d;
  logic [KEY_W-1:0] gnt_key_q, gnt_key_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic [1:0]       rr_q, rr_d;
  logic [7:0]       hold_q, hold_d;

  logic [KEY_W-1:0] keys    [4];
  logic [KEY_W-1:0] eff_key [4];
  logic [KEY_W-1:0] best_key;
  logic [1:0]       win_id;
  logic [1:0]       lane;
  logic             win_found;

`ifdef MIN_ARB_AGING_EN
  logic [3:0] age_q [4];
  logic [3:0] age_d [4];
`endif

  assign keys = '{key0, key1, key2, key3};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
`ifdef MIN_ARB_AGING_EN
      eff_key[i] = (keys[i] > KEY_W'(age_q[i])) ? keys[i] - KEY_W'(age_q[i]) : '0;
`else
      eff_key[i] = keys[i];
`endif
    end
  end

  // Scan from rr_q upward; strict less-than keeps the earliest lane on equal keys.
  always_comb begin
    win_found = 1'b0;
    win_id    = rr_q;
    best_key  = '0;
    lane      = rr_q;
    for (int j = 0; j < 4; j++) begin
      lane = rr_q + 2'(j);
      if (req[lane] && (!win_found || eff_key[lane] < best_key)) begin
        win_found = 1'b1;
        win_id    = lane;
        best_key  = eff_key[lane];
      end
    end
  end

  always_comb begin
    // NOTE: every *_d gets a default up front so no path leaves it unassigned (no latches).
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    gnt_key_d = gnt_key_q;
    rr_d      = rr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
`ifdef MIN_ARB_AGING_EN
    age_d     = age_q;
`endif

    unique case (state_q)
      S_IDLE: if (|req) state_d = S_ARB;
      S_ARB: begin
        if (|req) begin
          gnt_d     = 4'b0001 << win_id;
          gnt_id_d  = win_id;
          gnt_key_d = keys[win_id];
          rr_d      = win_id + 2'd1;
          hold_d    = '0;
          state_d   = S_GRANT;
`ifdef MIN_ARB_AGING_EN
          for (int i = 0; i < 4; i++) begin
            if (2'(i) == win_id)           age_d[i] = '0;
            else if (req[i] && age_q[i] != 4'hF) age_d[i] = age_q[i] + 4'd1;
          end
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        // done and owner drop take priority over the hold timeout.
        if (done || !req[gnt_id_q]) begin
          gnt_d   = '0;
          state_d = S_IDLE;
        end else if (hold_q == HOLD_LAST) begin
          gnt_d     = '0;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef MIN_ARB_AGING_EN
    for (int i = 0; i < 4; i++) if (!req[i]) age_d[i] = '0;
`endif
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      gnt_key_q <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      rr_q      <= '0;
      hold_q    <= '0;
`ifdef MIN_ARB_AGING_EN
      for (int i = 0; i < 4; i++) age_q[i] <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      gnt_key_q <= gnt_key_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      rr_q      <= rr_d;
      hold_q    <= hold_d;
`ifdef MIN_ARB_AGING_EN
      age_q     <= age_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign gnt_key = gnt_key_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule
